// File: rtl/hdlc_tx_scheduler.sv
// rtl/hdlc_tx_scheduler.sv - round-robin frame scheduler feeding one HDLC transmit core
//
// Purpose: arbitrates NUM_REQ frame requesters onto a single HDLC core. It
// streams the granted payload into Tx_Buff, starts transmission, polls Tx_SC
// for Tx_Done and reports one completion pulse per frame.
//
// Ports:
//   i_Clk, i_Rst             clock, asynchronous active-low reset
//   i_Req, i_ReqAbort        per-requester frame request / abort
//   o_Grant                  one-hot grant, held for the whole frame service
//   i_ByteValid/Data/Last    payload stream from the granted requester
//   o_ByteReady              payload stream handshake
//   o_Done/Aborted/Error     per-requester one-cycle completion pulses
//   o_Hdlc_Address           core register address (0 = Tx_SC, 1 = Tx_Buff)
//   o_Hdlc_WriteEnable       core write strobe
//   o_Hdlc_ReadEnable        core read strobe
//   o_Hdlc_DataIn            core write data
//   i_Hdlc_DataOut           core read data, valid one cycle after the read strobe
module hdlc_tx_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BYTES = 126,
   parameter int TIMEOUT   = 65535
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic [NUM_REQ-1:0] i_Req,
   input  logic [NUM_REQ-1:0] i_ReqAbort,
   output logic [NUM_REQ-1:0] o_Grant,
   input  logic               i_ByteValid,
   input  logic [7:0]         i_ByteData,
   input  logic               i_ByteLast,
   output logic               o_ByteReady,
   output logic [NUM_REQ-1:0] o_Done,
   output logic [NUM_REQ-1:0] o_Aborted,
   output logic [NUM_REQ-1:0] o_Error,
   output logic [2:0]         o_Hdlc_Address,
   output logic               o_Hdlc_WriteEnable,
   output logic               o_Hdlc_ReadEnable,
   output logic [7:0]         o_Hdlc_DataIn,
   input  logic [7:0]         i_Hdlc_DataOut
);

   localparam int          IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0]  MB = 8'(MAX_BYTES);
   localparam logic [31:0] TO = 32'(TIMEOUT);

   typedef enum logic [2:0] {IDLE, LOAD, START, POLL_RD, POLL_CHK, ABORT, FINISH} state_t;
   typedef enum logic [1:0] {END_OK, END_ERR, END_ABT} end_t;

   state_t             r_state;
   end_t               r_end;
   logic [NUM_REQ-1:0] r_grant;
   logic [IW-1:0]      r_last;
   logic               r_byte_ready;
   logic               r_aborting;
   logic [NUM_REQ-1:0] r_done;
   logic [NUM_REQ-1:0] r_aborted;
   logic [NUM_REQ-1:0] r_error;
   logic               r_we;
   logic               r_re;
   logic [7:0]         r_din;
   logic [7:0]         r_bcnt;
   logic [31:0]        r_tcnt;

   logic               w_any;
   logic [IW-1:0]      w_pick;
   logic               w_abort_g;
   logic               w_byte_ready;
   logic               w_xfer;
   logic [7:0]         w_bnext;
   logic [31:0]        w_tnext;
   logic               w_err_ovl;
   logic               w_err_to;
   logic               w_to_abort;
   logic               w_unused;

   // Candidate index for round-robin search: off positions above the last grant.
   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
      int s;
      s = (int'(base) + 1 + off) % NUM_REQ;
      return IW'(s);
   endfunction

   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_any && i_Req[rr_idx(r_last, i)]) begin
            w_any  = 1'b1;
            w_pick = rr_idx(r_last, i);
         end
      end
   end

   // Requester abort is only meaningful before the core abort is issued; once
   // the scheduler itself is aborting the frame, further aborts are ignored.
   assign w_abort_g = (r_state inside {LOAD, START, POLL_RD, POLL_CHK}) && !r_aborting
                      && (|(i_ReqAbort & r_grant));
   // Ready drops in the abort cycle so that a byte offered alongside an abort is not consumed.
   assign w_byte_ready = r_byte_ready && !w_abort_g;
   assign w_xfer       = (r_state == LOAD) && i_ByteValid && w_byte_ready;
   assign w_bnext      = r_bcnt + 8'd1;
   assign w_tnext      = r_tcnt + 32'd1;
   assign w_err_ovl    = w_xfer && !i_ByteLast && (w_bnext == MB);
   assign w_err_to     = ((r_state == POLL_RD) || (r_state == POLL_CHK)) && !r_aborting
                         && !w_abort_g && (w_tnext >= TO);
   assign w_to_abort   = w_abort_g || w_err_ovl || w_err_to;
   assign w_unused     = ^i_Hdlc_DataOut[7:1];

   // Buffer writes follow the stream handshake combinationally; all Tx_SC
   // accesses come from registered strobes and never overlap a buffer write.
   assign o_Grant            = r_grant;
   assign o_ByteReady        = w_byte_ready;
   assign o_Done             = r_done;
   assign o_Aborted          = r_aborted;
   assign o_Error            = r_error;
   assign o_Hdlc_WriteEnable = r_we || w_xfer;
   assign o_Hdlc_ReadEnable  = r_re;
   assign o_Hdlc_Address     = w_xfer ? 3'd1 : 3'd0;
   assign o_Hdlc_DataIn      = w_xfer ? i_ByteData : r_din;

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         r_state      <= IDLE;
         r_end        <= END_OK;
         r_grant      <= '0;
         r_last       <= IW'(NUM_REQ - 1);
         r_byte_ready <= 1'b0;
         r_aborting   <= 1'b0;
         r_done       <= '0;
         r_aborted    <= '0;
         r_error      <= '0;
         r_we         <= 1'b0;
         r_re         <= 1'b0;
         r_din        <= 8'h00;
         r_bcnt       <= 8'h00;
         r_tcnt       <= 32'd0;
      end else begin
         r_we      <= 1'b0;
         r_re      <= 1'b0;
         r_din     <= 8'h00;
         r_done    <= '0;
         r_aborted <= '0;
         r_error   <= '0;
         if (w_to_abort) begin
            r_state      <= ABORT;
            r_end        <= w_abort_g ? END_ABT : END_ERR;
            r_aborting   <= 1'b1;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b1;
            r_din        <= 8'h04;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_any) begin
                     r_grant      <= NUM_REQ'(1) << w_pick;
                     r_last       <= w_pick;
                     r_bcnt       <= 8'h00;
                     r_end        <= END_OK;
                     r_aborting   <= 1'b0;
                     r_byte_ready <= 1'b1;
                     r_state      <= LOAD;
                  end
               end
               LOAD: begin
                  if (w_xfer) begin
                     r_bcnt <= w_bnext;
                     if (i_ByteLast) begin
                        r_byte_ready <= 1'b0;
                        r_we         <= 1'b1;
                        r_din        <= 8'h02;
                        r_state      <= START;
                     end
                  end
               end
               START: begin
                  r_tcnt  <= 32'd0;
                  r_re    <= 1'b1;
                  r_state <= POLL_RD;
               end
               POLL_RD: begin
                  if (!r_aborting) r_tcnt <= w_tnext;
                  r_state <= POLL_CHK;
               end
               POLL_CHK: begin
                  if (!r_aborting) r_tcnt <= w_tnext;
                  if (i_Hdlc_DataOut[0]) begin
                     r_done    <= (r_end == END_OK)  ? r_grant : '0;
                     r_error   <= (r_end == END_ERR) ? r_grant : '0;
                     r_aborted <= (r_end == END_ABT) ? r_grant : '0;
                     r_state   <= FINISH;
                  end else begin
                     r_re    <= 1'b1;
                     r_state <= POLL_RD;
                  end
               end
               ABORT: begin
                  r_re    <= 1'b1;
                  r_state <= POLL_RD;
               end
               FINISH: begin
                  r_grant <= '0;
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hdlc_tx_scheduler.sv
// tb/tb_hdlc_tx_scheduler.sv - self-checking bench for hdlc_tx_scheduler
module tb_hdlc_tx_scheduler;

   localparam int EV_GNT  = 1;
   localparam int EV_WR1  = 2;
   localparam int EV_WR0  = 3;
   localparam int EV_DONE = 4;
   localparam int EV_ABT  = 5;
   localparam int EV_ERR  = 6;
   localparam int EV_BAD  = 9;

   typedef struct { int kind; int val; } ev_t;
   typedef struct { logic [3:0] req; int idx; int n; logic [7:0] b [4]; int da; } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] req_abort = '0;
   logic [3:0] grant;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = '0;
   logic       byte_last = 1'b0;
   logic       byte_ready;
   logic [3:0] done, aborted, error;
   logic [2:0] addr;
   logic       we, re;
   logic [7:0] din;
   logic [7:0] dout = '0;

   int   total = 0;
   int   bad = 0;
   ev_t  exp_q [$];
   int   done_after = 1000;
   int   rd_cnt = 0;
   int   rd_total = 0;
   int   low_cnt = 1;
   logic [3:0] prev_grant = '0;
   vec_t vt [5];

   hdlc_tx_scheduler #(.NUM_REQ(4), .MAX_BYTES(126), .TIMEOUT(20)) dut (
      .i_Clk(clk), .i_Rst(rst_n), .i_Req(req), .i_ReqAbort(req_abort), .o_Grant(grant),
      .i_ByteValid(byte_valid), .i_ByteData(byte_data), .i_ByteLast(byte_last),
      .o_ByteReady(byte_ready), .o_Done(done), .o_Aborted(aborted), .o_Error(error),
      .o_Hdlc_Address(addr), .o_Hdlc_WriteEnable(we), .o_Hdlc_ReadEnable(re),
      .o_Hdlc_DataIn(din), .i_Hdlc_DataOut(dout));

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
      end
   endfunction

   function automatic int oh_idx(input logic [3:0] v);
      if (!$onehot(v)) return 99;
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return 99;
   endfunction

   function automatic void exp_push(input int k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endfunction

   function automatic void observe(input int k, input int v);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_event", k, 0);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", k, e.kind);
         chk("event_val", v, e.val);
      end
   endfunction

   // Core model: Tx_SC read returns Tx_Done once done_after reads of this frame have been issued.
   always @(posedge clk) begin
      if (!rst_n || grant == 4'b0000) begin
         rd_cnt <= 0;
      end else if (re) begin
         rd_cnt <= rd_cnt + 1;
         dout   <= (rd_cnt + 1 >= done_after) ? 8'h01 : 8'h00;
      end
   end

   // Monitor: every core write, new grant and completion pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (grant != prev_grant && grant != 4'b0000) begin
            observe(EV_GNT, oh_idx(grant));
            chk("idle_gap", (low_cnt >= 1) ? 1 : 0, 1);
         end
         if (grant == 4'b0000) low_cnt++; else low_cnt = 0;
         chk("we_re_exclusive", {31'b0, we & re}, 0);
         if (we) observe((addr == 3'd1) ? EV_WR1 : (addr == 3'd0) ? EV_WR0 : EV_BAD, din);
         if (re) begin
            rd_total++;
            chk("rd_addr", addr, 0);
         end
         if (done != 4'b0000)    observe(EV_DONE, oh_idx(done));
         if (aborted != 4'b0000) observe(EV_ABT, oh_idx(aborted));
         if (error != 4'b0000)   observe(EV_ERR, oh_idx(error));
      end
      prev_grant = grant;
   end

   task automatic wait_new_grant(output bit ok);
      bit seen_low;
      seen_low = (grant == 4'b0000);
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (grant == 4'b0000) seen_low = 1'b1;
         else if (seen_low) ok = 1'b1;
      end
      chk("grant_within_bound", {31'b0, ok}, 1);
   endtask

   task automatic wait_finish();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk);
         if ((done | aborted | error) != 4'b0000) ok = 1'b1;
      end
      chk("finish_within_bound", {31'b0, ok}, 1);
   endtask

   task automatic push_byte(input logic [7:0] d, input logic l, output bit ok);
      byte_valid = 1'b1;
      byte_data  = d;
      byte_last  = l;
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (byte_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      byte_valid = 1'b0;
      byte_last  = 1'b0;
   endtask

   // Grant plus payload plus Tx_Enable write; returns one step into the START cycle.
   task automatic start_frame(input logic [3:0] rq, input int idx, input int n,
                              input logic [7:0] b [4], input int da, input bit drop);
      bit ok;
      done_after = da;
      exp_push(EV_GNT, idx);
      req = rq;
      wait_new_grant(ok);
      @(posedge clk);
      #1;
      if (drop) req = 4'b0000;
      for (int i = 0; i < n; i++) begin
         exp_push(EV_WR1, b[i]);
         push_byte(b[i], (i == n - 1), ok);
         chk("byte_accepted", {31'b0, ok}, 1);
      end
      exp_push(EV_WR0, 8'h02);
   endtask

   task automatic run_frame(input logic [3:0] rq, input int idx, input int n,
                            input logic [7:0] b [4], input int da, input bit drop);
      start_frame(rq, idx, n, b, da, drop);
      exp_push(EV_DONE, idx);
      wait_finish();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] bb [4];
      bit ok;
      int acc;
      int rd_start;

      vt[0].req = 4'b0001; vt[0].idx = 0; vt[0].n = 3; vt[0].b = '{8'hA5, 8'h5A, 8'h7E, 8'h00}; vt[0].da = 2;
      vt[1].req = 4'b0101; vt[1].idx = 2; vt[1].n = 1; vt[1].b = '{8'h11, 8'h00, 8'h00, 8'h00}; vt[1].da = 1;
      vt[2].req = 4'b0101; vt[2].idx = 0; vt[2].n = 2; vt[2].b = '{8'hC3, 8'h3C, 8'h00, 8'h00}; vt[2].da = 3;
      vt[3].req = 4'b1000; vt[3].idx = 3; vt[3].n = 4; vt[3].b = '{8'h00, 8'hFF, 8'h80, 8'h01}; vt[3].da = 1;
      vt[4].req = 4'b0110; vt[4].idx = 1; vt[4].n = 1; vt[4].b = '{8'h42, 8'h00, 8'h00, 8'h00}; vt[4].da = 2;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_we", we, 0);
      chk("rst_re", re, 0);
      chk("rst_addr", addr, 0);
      chk("rst_din", din, 0);
      chk("rst_pulses", done | aborted | error, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Table of normal frames: requester pattern, payload, poll length.
      for (int i = 0; i < 5; i++) run_frame(vt[i].req, vt[i].idx, vt[i].n, vt[i].b, vt[i].da, 1'b1);

      // All requesters held: rotation 0,1,2,3,0 from reset.
      do_reset();
      bb = '{8'h10, 8'h00, 8'h00, 8'h00};
      for (int j = 0; j < 5; j++) begin
         bb[0] = 8'(8'h10 + j);
         run_frame(4'b1111, j % 4, 1, bb, 1, 1'b0);
      end
      req = 4'b0000;

      // Overlength: 126 buffer writes, then abort, then Error.
      done_after = 2;
      exp_push(EV_GNT, 2);
      req = 4'b0100;
      wait_new_grant(ok);
      @(posedge clk);
      #1;
      req = 4'b0000;
      acc = 0;
      for (int i = 0; i < 126; i++) begin
         exp_push(EV_WR1, i);
         push_byte(8'(i), 1'b0, ok);
         if (ok) acc++;
      end
      chk("ovl_accepted", acc, 126);
      exp_push(EV_WR0, 8'h04);
      exp_push(EV_ERR, 2);
      byte_valid = 1'b1;
      byte_data  = 8'hEE;
      acc = 0;
      repeat (4) begin
         @(negedge clk);
         if (byte_ready) acc++;
      end
      chk("ovl_127th_refused", acc, 0);
      byte_valid = 1'b0;
      wait_finish();

      // Abort raised in POLL_CHK together with Tx_Done.
      bb = '{8'h99, 8'h00, 8'h00, 8'h00};
      start_frame(4'b0010, 1, 1, bb, 1, 1'b1);
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         if (re) ok = 1'b1;
      end
      chk("first_poll_read", {31'b0, ok}, 1);
      @(posedge clk);
      #1;
      exp_push(EV_WR0, 8'h04);
      exp_push(EV_ABT, 1);
      req_abort = 4'b0010;
      @(posedge clk);
      #1;
      req_abort = 4'b0000;
      wait_finish();

      // Timeout: Tx_Done held low for 20 poll cycles (10 reads).
      bb = '{8'h5C, 8'h00, 8'h00, 8'h00};
      start_frame(4'b1000, 3, 1, bb, 1000, 1'b1);
      rd_start = rd_total;
      exp_push(EV_WR0, 8'h04);
      exp_push(EV_ERR, 3);
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk);
         if (we && din == 8'h04) ok = 1'b1;
      end
      chk("timeout_abort_seen", {31'b0, ok}, 1);
      chk("timeout_reads", rd_total - rd_start, 10);
      done_after = 0;
      wait_finish();

      // Reset after two bytes in LOAD.
      done_after = 1000;
      exp_push(EV_GNT, 0);
      req = 4'b0001;
      wait_new_grant(ok);
      @(posedge clk);
      #1;
      req = 4'b0000;
      exp_push(EV_WR1, 8'h11);
      push_byte(8'h11, 1'b0, ok);
      exp_push(EV_WR1, 8'h22);
      push_byte(8'h22, 1'b0, ok);
      byte_valid = 1'b1;
      byte_data  = 8'h33;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_grant", grant, 0);
      chk("midrst_byte_ready", byte_ready, 0);
      chk("midrst_we", we, 0);
      chk("midrst_addr", addr, 0);
      chk("midrst_din", din, 0);
      acc = 0;
      repeat (3) begin
         @(negedge clk);
         if (we || re) acc++;
      end
      chk("midrst_no_strobe", acc, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      byte_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bb = '{8'hDE, 8'hAD, 8'h00, 8'h00};
      run_frame(4'b0010, 1, 2, bb, 1, 1'b1);

      repeat (3) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
